// File: rtl/hzrd_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB destination tags, raises load-use stalls, selects bypasses.
module hzrd_fwd_unit #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    input  logic                      i_id_rd_wen,
    input  logic [ADDR_W-1:0]         i_id_rd_waddr,
    input  logic                      i_id_is_load,
    input  logic [NUM_SRC*ADDR_W-1:0] i_id_rs_addr,
    input  logic [NUM_SRC-1:0]        i_id_rs_used,
    input  logic                      i_flush,
    input  logic                      i_stall_ext,
    output logic                      o_if_id_halt,
    output logic                      o_id_ex_halt,
    output logic [2*NUM_SRC-1:0]      o_fwd_sel,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic              is_load;
    } tag_t;

    tag_t                      ex_q;
    tag_t                      mem_q;
    tag_t                      wb_q;
    logic [NUM_SRC*ADDR_W-1:0] ex_rs_q;
    logic [NUM_SRC-1:0]        ex_used_q;
    logic [CNT_W-1:0]          cnt_q;

    logic ex_prod;
    logic mem_prod;
    logic wb_prod;
    logic src_hit;
    logic load_use;
    logic bubble;
    logic halt;
    logic cnt_inc;

    assign ex_prod  = ex_q.valid  & ex_q.wen  & (ex_q.waddr  != '0);
    assign mem_prod = mem_q.valid & mem_q.wen & (mem_q.waddr != '0);
    assign wb_prod  = wb_q.valid  & wb_q.wen  & (wb_q.waddr  != '0);

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_id_rs_used[k] &&
                i_id_rs_addr[k*ADDR_W +: ADDR_W] == ex_q.waddr)
                src_hit = 1'b1;
        end
    end

    assign load_use = i_id_valid & ex_prod & ex_q.is_load & src_hit;

    always_comb begin
        halt = 1'b0;
        if (i_rst)
            halt = 1'b0;
        else if (i_stall_ext)
            halt = 1'b1;
        else if (i_flush)
            halt = 1'b0;
        else
            halt = load_use;
    end

    assign o_if_id_halt = halt;
    assign o_id_ex_halt = halt;
    assign bubble       = i_flush | load_use;
    assign cnt_inc      = load_use & ~i_flush & ~i_stall_ext;

    // Bypass only for a live EX instruction; MEM loads fall through to WB.
    always_comb begin
        o_fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_q.valid && ex_used_q[k]) begin
                if (mem_prod && !mem_q.is_load &&
                    mem_q.waddr == ex_rs_q[k*ADDR_W +: ADDR_W])
                    o_fwd_sel[2*k +: 2] = 2'b01;
                else if (wb_prod &&
                         wb_q.waddr == ex_rs_q[k*ADDR_W +: ADDR_W])
                    o_fwd_sel[2*k +: 2] = 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs_q   <= '0;
            ex_used_q <= '0;
        end else if (!i_stall_ext) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble) begin
                ex_q      <= '0;
                ex_rs_q   <= '0;
                ex_used_q <= '0;
            end else begin
                ex_q.valid   <= i_id_valid;
                ex_q.wen     <= i_id_rd_wen;
                ex_q.waddr   <= i_id_rd_waddr;
                ex_q.is_load <= i_id_is_load;
                ex_rs_q      <= i_id_rs_addr;
                ex_used_q    <= i_id_rs_used;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else if (cnt_inc && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hzrd_fwd_unit.sv
// Scoreboard bench for hzrd_fwd_unit: directed scenarios plus random traffic,
// checked against an instruction-level pipeline model.
module tb_hzrd_fwd_unit;

    localparam int AW = 5;

    typedef struct {
        bit v;
        bit w;
        bit ld;
        int rd;
        int rs[2];
        bit u[2];
    } ins_t;

    typedef struct {
        bit       halt;
        bit [3:0] fwd;
        int       cnt;
        int       cnt2;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic          id_wen;
    logic [AW-1:0] id_rd;
    logic          id_load;
    logic [2*AW-1:0] id_rs;
    logic [1:0]    id_used;
    logic          flush;
    logic          ext;
    logic          if_halt;
    logic          ex_halt;
    logic [3:0]    fwd;
    logic [15:0]   cnt;
    logic          if_halt2;
    logic          ex_halt2;
    logic [3:0]    fwd2;
    logic [1:0]    cnt2;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    ins_t st[3];
    int   m_cnt = 0;
    int   m_cnt2 = 0;
    bit   stim_done = 0;

    hzrd_fwd_unit u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rd_wen(id_wen),
        .i_id_rd_waddr(id_rd), .i_id_is_load(id_load),
        .i_id_rs_addr(id_rs), .i_id_rs_used(id_used),
        .i_flush(flush), .i_stall_ext(ext),
        .o_if_id_halt(if_halt), .o_id_ex_halt(ex_halt),
        .o_fwd_sel(fwd), .o_stall_cnt(cnt)
    );

    hzrd_fwd_unit #(.CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rd_wen(id_wen),
        .i_id_rd_waddr(id_rd), .i_id_is_load(id_load),
        .i_id_rs_addr(id_rs), .i_id_rs_used(id_used),
        .i_flush(flush), .i_stall_ext(ext),
        .o_if_id_halt(if_halt2), .o_id_ex_halt(ex_halt2),
        .o_fwd_sel(fwd2), .o_stall_cnt(cnt2)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic bit prod(ins_t x);
        return x.v && x.w && x.rd != 0;
    endfunction

    function automatic ins_t mk(bit v, bit w, int rd, bit ld,
                                int r0, int r1, bit u0, bit u1);
        ins_t x;
        x.v = v; x.w = w; x.rd = rd; x.ld = ld;
        x.rs[0] = r0; x.rs[1] = r1; x.u[0] = u0; x.u[1] = u1;
        return x;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Apply one cycle of ID inputs, predict the outputs, advance the model.
    task automatic step(ins_t id, bit fl, bit ex, bit rs);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        id_valid = id.v;
        id_wen   = id.w;
        id_rd    = AW'(id.rd);
        id_load  = id.ld;
        id_rs    = {AW'(id.rs[1]), AW'(id.rs[0])};
        id_used  = {id.u[1], id.u[0]};
        flush    = fl;
        ext      = ex;
        rst      = rs;
        lu = id.v && prod(st[0]) && st[0].ld &&
             ((id.u[0] && id.rs[0] == st[0].rd) ||
              (id.u[1] && id.rs[1] == st[0].rd));
        if (rs) begin
            for (int i = 0; i < 3; i++) st[i] = nop();
            m_cnt  = 0;
            m_cnt2 = 0;
        end
        e.halt = rs ? 0 : ex ? 1 : fl ? 0 : lu;
        e.fwd  = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            if (!rs && st[0].v && st[0].u[k]) begin
                if (prod(st[1]) && !st[1].ld && st[1].rd == st[0].rs[k])
                    e.fwd[2*k +: 2] = 2'b01;
                else if (prod(st[2]) && st[2].rd == st[0].rs[k])
                    e.fwd[2*k +: 2] = 2'b10;
            end
        end
        e.cnt  = m_cnt;
        e.cnt2 = m_cnt2;
        exp_q.push_back(e);
        if (!rs && !ex) begin
            st[2] = st[1];
            st[1] = st[0];
            st[0] = (fl || lu) ? nop() : id;
            if (lu && !fl) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (if_halt !== e.halt || ex_halt !== e.halt) begin
                miscompares++;
                $display("FAIL halt: got if=%b ex=%b want %b",
                         if_halt, ex_halt, e.halt);
            end
            if (fwd !== e.fwd) begin
                miscompares++;
                $display("FAIL fwd_sel: got %b want %b", fwd, e.fwd);
            end
            if (cnt !== 16'(e.cnt)) begin
                miscompares++;
                $display("FAIL stall_cnt: got %0d want %0d", cnt, e.cnt);
            end
            if (cnt2 !== 2'(e.cnt2) || fwd2 !== e.fwd ||
                if_halt2 !== e.halt) begin
                miscompares++;
                $display("FAIL sat_unit: got cnt=%0d fwd=%b h=%b want cnt=%0d fwd=%b h=%b",
                         cnt2, fwd2, if_halt2, e.cnt2, e.fwd, e.halt);
            end
        end
    end

    initial begin
        ins_t lw5;
        ins_t use5;
        ins_t x;
        rst = 1; id_valid = 0; id_wen = 0; id_rd = '0; id_load = 0;
        id_rs = '0; id_used = '0; flush = 0; ext = 0;
        for (int i = 0; i < 3; i++) st[i] = nop();
        repeat (3) step(nop(), 0, 0, 1);

        lw5  = mk(1, 1, 5, 1, 0, 0, 0, 0);
        use5 = mk(1, 1, 6, 0, 5, 0, 1, 0);
        step(lw5, 0, 0, 0);
        step(use5, 0, 0, 0);
        step(use5, 0, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        step(mk(1, 1, 3, 0, 1, 2, 1, 1), 0, 0, 0);
        step(mk(1, 1, 4, 0, 3, 3, 1, 1), 0, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        step(mk(1, 1, 3, 0, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 3, 0, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 7, 0, 3, 0, 1, 0), 0, 0, 0);
        step(nop(), 0, 0, 0);
        step(mk(1, 1, 3, 0, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 9, 0, 1, 1, 1, 1), 0, 0, 0);
        step(mk(1, 1, 7, 0, 0, 3, 0, 1), 0, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        step(mk(1, 1, 0, 1, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 8, 0, 0, 0, 1, 1), 0, 0, 0);
        step(mk(1, 0, 4, 1, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 8, 0, 4, 4, 1, 1), 0, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        step(lw5, 0, 0, 0);
        step(use5, 1, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        step(nop(), 0, 0, 1);
        step(lw5, 0, 0, 0);
        repeat (3) step(use5, 0, 1, 0);
        step(use5, 0, 0, 0);
        step(use5, 0, 0, 0);
        repeat (5) begin
            step(lw5, 0, 0, 0);
            step(use5, 0, 0, 0);
            step(use5, 0, 0, 0);
        end
        step(lw5, 0, 0, 0);
        step(use5, 0, 1, 1);
        step(use5, 0, 0, 0);
        repeat (3) step(nop(), 0, 0, 0);

        repeat (4000) begin
            x.v     = $urandom_range(9, 0) != 0;
            x.w     = $urandom_range(9, 0) < 7;
            x.ld    = $urandom_range(9, 0) < 3;
            x.rd    = $urandom_range(3, 0);
            x.rs[0] = $urandom_range(3, 0);
            x.rs[1] = $urandom_range(3, 0);
            x.u[0]  = $urandom_range(1, 0) != 0;
            x.u[1]  = $urandom_range(1, 0) != 0;
            step(x, $urandom_range(19, 0) == 0,
                 $urandom_range(99, 0) < 15,
                 $urandom_range(99, 0) == 0);
        end
        stim_done = 1;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hzrd_fwd_unit.md
HZRD_FWD_UNIT -- requirements
Module: hzrd_fwd_unit

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 16, stall counter width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, global clock.
- i_rst, in, 1, global reset.
- i_id_valid, in, 1, ID stage holds a valid instruction.
- i_id_rd_wen, in, 1, ID instruction writes the register file.
- i_id_rd_waddr, in, ADDR_W, ID destination address.
- i_id_is_load, in, 1, ID instruction is a load.
- i_id_rs_addr, in, NUM_SRC*ADDR_W, ID source addresses; source k at bits [k*ADDR_W +: ADDR_W].
- i_id_rs_used, in, NUM_SRC, ID source k is read.
- i_flush, in, 1, kill the ID instruction (branch redirect).
- i_stall_ext, in, 1, external freeze (memory wait).
- o_if_id_halt, out, 1, hold the PC and the IF/ID register.
- o_id_ex_halt, out, 1, insert a bubble into ID/EX.
- o_fwd_sel, out, 2*NUM_SRC, per EX source: 00 regfile, 01 ALU result in MEM, 10 result in WB.
- o_stall_cnt, out, CNT_W, saturating count of hazard-stall cycles.
REQ-003 Clock and reset SHALL be i_clk and i_rst; reset SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL keep one tag slot per stage for EX, MEM and WB; each slot holds {valid, wen, waddr, is_load}, and the EX slot also holds the source addresses and used bits.
REQ-005 Each cycle without a freeze, the WB slot SHALL take the MEM slot and the MEM slot SHALL take the EX slot.
REQ-006 Each cycle without a freeze, the EX slot SHALL load the ID inputs, or load an invalid bubble when a stall or flush is active.
REQ-007 A slot SHALL count as a producer only when valid=1, wen=1 and waddr is not 0; register 0 SHALL never cause a hazard or a forward.
REQ-008 A load-use stall SHALL occur when i_id_valid=1, the EX slot is a producer with is_load=1, and any used ID source matches the EX waddr.
REQ-009 During a load-use stall, o_if_id_halt and o_id_ex_halt SHALL both be 1 combinationally in the same cycle; the stall lasts exactly 1 cycle per load.
REQ-010 o_fwd_sel for EX source k SHALL be combinational and SHALL only select a forward when the source is used.
- 01 if the MEM slot is a producer, has is_load=0, and its waddr matches.
- Otherwise 10 if the WB slot is a producer and its waddr matches.
- Otherwise 00.
REQ-011 A MEM-slot load matching an EX source SHALL be unreachable because of REQ-008; if it occurs anyway, the select SHALL fall through to the WB check.
REQ-012 When i_flush=1, the EX slot SHALL load a bubble and both halts SHALL be 0, whatever the stall condition; flush has priority over stall.
REQ-013 When i_stall_ext=1, all slots SHALL hold their values and both halts SHALL be 1.
REQ-014 i_stall_ext SHALL have priority over flush and stall; a flush seen during a freeze is ignored, and the pipeline controller holds i_flush until the freeze ends.
REQ-015 o_stall_cnt SHALL increment by 1 on each clock edge where a REQ-008 stall is active and i_stall_ext=0.
REQ-016 o_stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 The block SHALL infer no combinational path from o_fwd_sel back to the halts.

Reset
REQ-018 While i_rst=1, all slots SHALL be invalid and o_stall_cnt SHALL be 0; as a result o_fwd_sel=0 and both halts=0.
REQ-019 Reset asserted mid-stall SHALL clear the stall within the same cycle, with no residual bubble or count.

Verification
REQ-020 A bench SHALL cover these directed scenarios, one per line: stimulus -> required response.
- Load x5 in ID, then ADD reading x5 -> one cycle with both halts=1; the next EX slot is a bubble; the ADD then reaches EX with o_fwd_sel[1:0]=10; o_stall_cnt=1.
- ADD x3, then SUB reading x3 on both sources, back-to-back -> no halt; the SUB in EX sees o_fwd_sel=0101.
- ADD x3, ADD x3, then OR reading x3 -> OR in EX sees 01 (youngest wins); with one unrelated instruction in between, it sees 10.
- Producer with rd=x0, or i_id_rd_wen=0 -> o_fwd_sel=00 and no halt, even on address match.
- Load-use condition with i_flush=1 in the same cycle -> halts=0, EX slot becomes a bubble, o_stall_cnt unchanged.
- i_stall_ext=1 for 3 cycles during a load-use -> slots frozen and halts=1; the count rises only after the freeze; with CNT_W=2 and 5 stalls, o_stall_cnt holds at 3.
